// File: rtl/ret_stack_pkg.sv
// Shared types and defaults for the return-address stack.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ret_stack_pkg;

   // Default address width (matches the program counter) and stack depth.
   localparam int DEF_D     = 12;
   localparam int DEF_DEPTH = 8;

   // Operation decode of {call_en, ret_en}.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_SWAP = 2'b11
   } stack_op_t;

   typedef logic [DEF_D-1:0] addr_t;

endpackage

// File: rtl/ret_stack_mem.sv
// Storage array for the return-address stack: one sync write, one comb read.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; a write is accepted every cycle we is high.
module ret_stack_mem
   import ret_stack_pkg::*;
#(
   parameter int D     = DEF_D,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PW    = $clog2(DEPTH)
)
(
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [D-1:0]  wdata,
   input  logic [PW-1:0] raddr,
   output logic [D-1:0]  rdata
);

   // Contents carry no reset: empty/depth tracking makes stale data invisible.
   logic [D-1:0] mem [DEPTH];

   // Single write port; a same-cycle read still sees the old contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: push link address on call, pop on return.
// Latency: ret_addr/ret_valid registered, valid exactly 1 cycle after ret_en.
// Backpressure: none; overflow overwrites the oldest entry, underflow returns 0, both flagged sticky.
module ret_addr_stack
   import ret_stack_pkg::*;
#(
   parameter int D     = DEF_D,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PW    = $clog2(DEPTH)
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          call_en,
   input  logic [D-1:0]  link_addr,
   input  logic          ret_en,
   input  logic          clr_err,
   output logic [D-1:0]  ret_addr,
   output logic          ret_valid,
   output logic [PW:0]   depth_cnt,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   stack_op_t     op;
   logic [PW-1:0] sp;
   logic [PW-1:0] top;
   logic [D-1:0]  top_dat;
   logic          mem_we;
   logic [PW-1:0] mem_waddr;
   logic          ovf_set;
   logic          unf_set;

   assign op    = stack_op_t'({call_en, ret_en});
   // sp is a power-of-two modulus counter, so top wraps for free.
   assign top   = sp - 1'b1;
   assign empty = (depth_cnt == '0);
   assign full  = (depth_cnt == FULL_CNT);

   assign ovf_set = (op == OP_PUSH) && full;
   assign unf_set = ((op == OP_POP) || (op == OP_SWAP)) && empty;

   // Write-port steering: pushes land at sp, a non-empty swap replaces the top.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = sp;
      unique case (op)
         OP_PUSH: begin
            mem_we    = 1'b1;
            mem_waddr = sp;
         end
         OP_SWAP: begin
            mem_we    = 1'b1;
            mem_waddr = empty ? sp : top;
         end
         OP_POP,
         OP_NONE: begin
            mem_we    = 1'b0;
            mem_waddr = sp;
         end
      endcase
   end

   ret_stack_mem #(
      .D     (D),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (link_addr),
      .raddr (top),
      .rdata (top_dat)
   );

   // Pointer, occupancy, return register and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp        <= '0;
         depth_cnt <= '0;
         ret_addr  <= '0;
         ret_valid <= 1'b0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else begin
         ret_valid <= 1'b0;
         unique case (op)
            OP_NONE: begin
            end
            OP_PUSH: begin
               sp <= sp + 1'b1;
               // Full push overwrites the oldest slot; occupancy saturates.
               if (!full) begin
                  depth_cnt <= depth_cnt + 1'b1;
               end
            end
            OP_POP: begin
               ret_valid <= 1'b1;
               if (empty) begin
                  ret_addr <= '0;
               end else begin
                  ret_addr  <= top_dat;
                  sp        <= top;
                  depth_cnt <= depth_cnt - 1'b1;
               end
            end
            OP_SWAP: begin
               ret_valid <= 1'b1;
               if (empty) begin
                  // Nothing to return; the call still lands as the sole entry.
                  ret_addr  <= '0;
                  sp        <= sp + 1'b1;
                  depth_cnt <= (PW+1)'(1);
               end else begin
                  ret_addr <= top_dat;
               end
            end
         endcase

         // A new error outranks a simultaneous clear.
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (clr_err) begin
            ovf <= 1'b0;
         end

         if (unf_set) begin
            unf <= 1'b1;
         end else if (clr_err) begin
            unf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed cases with literal expectations, then random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_ret_addr_stack;

   localparam int D     = 12;
   localparam int DEPTH = 8;
   localparam int PW    = 3;

   logic          clk;
   logic          reset;
   logic          call_en;
   logic [D-1:0]  link_addr;
   logic          ret_en;
   logic          clr_err;
   logic [D-1:0]  ret_addr;
   logic          ret_valid;
   logic [PW:0]   depth_cnt;
   logic          empty;
   logic          full;
   logic          ovf;
   logic          unf;

   int n_checks = 0;
   int n_fail   = 0;

   ret_addr_stack #(.D(D), .DEPTH(DEPTH), .PW(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .call_en   (call_en),
      .link_addr (link_addr),
      .ret_en    (ret_en),
      .clr_err   (clr_err),
      .ret_addr  (ret_addr),
      .ret_valid (ret_valid),
      .depth_cnt (depth_cnt),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf),
      .unf       (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue whose back is the top of stack.
   logic [D-1:0] q[$];
   logic [D-1:0] m_ret_addr = '0;
   logic         m_ret_valid = 1'b0;
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;
   bit           model_ok = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_ret_addr  = '0;
         m_ret_valid = 1'b0;
         m_ovf       = 1'b0;
         m_unf       = 1'b0;
         model_ok    = 1'b1;
      end else begin
         bit new_ovf;
         bit new_unf;
         new_ovf = 1'b0;
         new_unf = 1'b0;
         m_ret_valid = 1'b0;
         if (call_en && !ret_en) begin
            if (q.size() == DEPTH) begin
               void'(q.pop_front());
               new_ovf = 1'b1;
            end
            q.push_back(link_addr);
         end else if (!call_en && ret_en) begin
            m_ret_valid = 1'b1;
            if (q.size() == 0) begin
               m_ret_addr = '0;
               new_unf = 1'b1;
            end else begin
               m_ret_addr = q.pop_back();
            end
         end else if (call_en && ret_en) begin
            m_ret_valid = 1'b1;
            if (q.size() == 0) begin
               m_ret_addr = '0;
               new_unf = 1'b1;
               q.push_back(link_addr);
            end else begin
               m_ret_addr = q[q.size()-1];
               q[q.size()-1] = link_addr;
            end
         end
         m_ovf = new_ovf || (m_ovf && !clr_err);
         m_unf = new_unf || (m_unf && !clr_err);
      end
   end

   // Every cycle after the first reset, outputs must match the model.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("ret_valid", 32'(ret_valid), 32'(m_ret_valid));
         chk("ret_addr",  32'(ret_addr),  32'(m_ret_addr));
         chk("depth_cnt", 32'(depth_cnt), 32'(q.size()));
         chk("empty",     32'(empty),     32'(q.size() == 0));
         chk("full",      32'(full),      32'(q.size() == DEPTH));
         chk("ovf",       32'(ovf),       32'(m_ovf));
         chk("unf",       32'(unf),       32'(m_unf));
      end
   end

   task automatic drive(input logic c, input logic r, input logic [D-1:0] l,
                        input logic ce, input logic rs);
      call_en   = c;
      ret_en    = r;
      link_addr = l;
      clr_err   = ce;
      reset     = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [D-1:0] l);
      drive(1'b1, 1'b0, l, 1'b0, 1'b0);
   endtask

   task automatic pop();
      drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      call_en   = 1'b0;
      ret_en    = 1'b0;
      link_addr = '0;
      clr_err   = 1'b0;
      reset     = 1'b1;
      do_reset();
      do_reset();

      // Reset state
      chk("rst_ret_valid", 32'(ret_valid), 0);
      chk("rst_ret_addr",  32'(ret_addr),  0);
      chk("rst_depth",     32'(depth_cnt), 0);
      chk("rst_empty",     32'(empty),     1);
      chk("rst_full",      32'(full),      0);
      chk("rst_ovf",       32'(ovf),       0);
      chk("rst_unf",       32'(unf),       0);

      // LIFO order, one-cycle latency
      push(12'h010); push(12'h020); push(12'h030);
      chk("lifo_depth3", 32'(depth_cnt), 3);
      pop();
      chk("lifo_pop1", 32'(ret_addr), 32'h030);
      chk("lifo_vld1", 32'(ret_valid), 1);
      pop();
      chk("lifo_pop2", 32'(ret_addr), 32'h020);
      chk("lifo_vld2", 32'(ret_valid), 1);
      pop();
      chk("lifo_pop3", 32'(ret_addr), 32'h010);
      chk("lifo_empty", 32'(empty), 1);
      idle();
      chk("lifo_vld_drop", 32'(ret_valid), 0);

      // Overflow wraps over the oldest entry
      for (int i = 0; i < 8; i++) push(12'(12'h100 + i));
      chk("ovf_full8", 32'(full), 1);
      chk("ovf_notyet", 32'(ovf), 0);
      push(12'h108);
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_depth", 32'(depth_cnt), 8);
      pop();
      chk("ovf_first_pop", 32'(ret_addr), 32'h108);
      for (int i = 0; i < 7; i++) pop();
      chk("ovf_last_pop", 32'(ret_addr), 32'h101);
      chk("ovf_drained", 32'(depth_cnt), 0);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("ovf_cleared", 32'(ovf), 0);

      // Underflow from empty
      do_reset();
      pop();
      chk("unf_vld", 32'(ret_valid), 1);
      chk("unf_addr", 32'(ret_addr), 0);
      chk("unf_flag", 32'(unf), 1);
      chk("unf_depth", 32'(depth_cnt), 0);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("unf_cleared", 32'(unf), 0);
      // Error coinciding with clear keeps the flag
      drive(1'b0, 1'b1, '0, 1'b1, 1'b0);
      chk("unf_wins_clr", 32'(unf), 1);

      // Swap
      do_reset();
      push(12'h0AA);
      drive(1'b1, 1'b1, 12'h0BB, 1'b0, 1'b0);
      chk("swap_ret", 32'(ret_addr), 32'h0AA);
      chk("swap_depth", 32'(depth_cnt), 1);
      pop();
      chk("swap_next", 32'(ret_addr), 32'h0BB);

      // Reset mid-sequence with ret_en held
      push(12'h011); push(12'h022);
      drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
      chk("midrst_vld", 32'(ret_valid), 0);
      chk("midrst_depth", 32'(depth_cnt), 0);
      chk("midrst_empty", 32'(empty), 1);
      chk("midrst_ovf", 32'(ovf), 0);
      chk("midrst_unf", 32'(unf), 0);

      // Push then immediate pop
      push(12'h123);
      pop();
      chk("bypass_addr", 32'(ret_addr), 32'h123);
      chk("bypass_vld", 32'(ret_valid), 1);

      // Random traffic in phases biased toward filling or draining
      for (int i = 0; i < 2000; i++) begin
         int r;
         int push_pct;
         logic c, rt, ce, rs;
         push_pct = ((i / 250) % 2 == 0) ? 70 : 30;
         r  = int'($urandom_range(0, 99));
         c  = (r < push_pct);
         rt = (int'($urandom_range(0, 99)) < (100 - push_pct)) || (r >= 95);
         ce = ($urandom_range(0, 29) == 0);
         rs = ($urandom_range(0, 399) == 0);
         drive(c, rt, 12'($urandom_range(0, 4095)), ce, rs);
      end
      idle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
